// File: rtl/npu_dma_pkg.sv
// ---------------------------------------------------------------------------
// npu_dma_pkg
// Shared definitions for the NPU streaming DMA engine:
//   - dma_state_t   : top-level control FSM encoding (IDLE / RUN / FINISH)
//   - WORD_BYTES    : byte stride between consecutive 32-bit words
//   - ROW_IN_WORDS  : stream words per core row on the input side (N=8)
//   - ROW_OUT_WORDS : stream words per core row on the result side (N=8)
// ---------------------------------------------------------------------------
package npu_dma_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } dma_state_t;

    localparam int WORD_BYTES    = 4;
    localparam int ROW_IN_WORDS  = 2;
    localparam int ROW_OUT_WORDS = 8;

endpackage

// File: rtl/npu_dma_rd_fifo.sv
// ---------------------------------------------------------------------------
// npu_dma_rd_fifo
// Synchronous first-word-fall-through FIFO buffering MM2S read data.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data this cycle
//   push_data   : 32-bit word to store
//   pop         : consume the head word this cycle
//   head_data   : current head word (valid whenever empty is 0)
//   empty       : no words stored
//   count       : number of stored words (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module npu_dma_rd_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          pop,
    output logic [31:0]   head_data,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is only allowed when the head leaves in the
    // same cycle; the DMA credit scheme never needs more than that.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_COUNT) || do_pop);

    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/npu_stream_dma.sv
// ---------------------------------------------------------------------------
// npu_stream_dma
// Memory-side DMA engine for the sequencer's 32-bit streaming interface.
//   MM2S: Avalon-MM read master (rd_*) fetches in_words words from src_addr
//         and streams them out on st_out_* (valid/ready).
//   S2MM: accepts out_words words on st_in_* and writes them to dst_addr
//         through the Avalon-MM write master (wr_*).
// Control: start (1-cycle pulse, honoured only when idle), busy, done
//          (1-cycle pulse once both directions have moved all words).
// Optional feature macro NPU_DMA_PERF_EN adds perf_cycles, perf_rd_stall
// and perf_wr_stall counters; without it those ports do not exist.
// ---------------------------------------------------------------------------
module npu_stream_dma
    import npu_dma_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int RD_FIFO_DEPTH = 8,
    parameter int RD_FIFO_AW    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [31:0]           in_words,
    input  logic [31:0]           out_words,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_address,
    output logic                  rd_read,
    input  logic                  rd_waitrequest,
    input  logic [31:0]           rd_readdata,
    input  logic                  rd_readdatavalid,
    output logic [31:0]           st_out_data,
    output logic                  st_out_valid,
    input  logic                  st_out_ready,
    input  logic [31:0]           st_in_data,
    input  logic                  st_in_valid,
    output logic                  st_in_ready,
    output logic [ADDR_WIDTH-1:0] wr_address,
    output logic                  wr_write,
    output logic [31:0]           wr_writedata,
    input  logic                  wr_waitrequest
`ifdef NPU_DMA_PERF_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_rd_stall,
    output logic [31:0]           perf_wr_stall
`endif
);

    localparam logic [RD_FIFO_AW+1:0] CREDIT_LIMIT = (RD_FIFO_AW + 2)'(RD_FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP    = ADDR_WIDTH'(WORD_BYTES);

    dma_state_t state;
    dma_state_t state_next;

    logic [31:0]           in_words_q;
    logic [31:0]           out_words_q;
    logic [31:0]           rd_issued;
    logic [31:0]           rd_words_streamed;
    logic [31:0]           wr_words_accepted;
    logic [31:0]           wr_words_done;
    logic [RD_FIFO_AW:0]   rd_outstanding;
    logic [RD_FIFO_AW:0]   fifo_count;
    logic [RD_FIFO_AW+1:0] credit_used;
    logic [31:0]           fifo_head;
    logic                  fifo_empty;

    logic start_accept;
    logic rd_accept;
    logic st_out_fire;
    logic st_in_fire;
    logic wr_accept;

    assign start_accept = (state == IDLE) && start;
    assign rd_accept    = rd_read && !rd_waitrequest;
    assign st_out_fire  = st_out_valid && st_out_ready;
    assign st_in_fire   = st_in_valid && st_in_ready;
    assign wr_accept    = wr_write && !wr_waitrequest;

    // Requests in flight plus words already buffered may never exceed the
    // FIFO depth, so every returned word is guaranteed a free slot.
    assign credit_used = {1'b0, rd_outstanding} + {1'b0, fifo_count};

    npu_dma_rd_fifo #(
        .DEPTH (RD_FIFO_DEPTH),
        .AW    (RD_FIFO_AW)
    ) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_readdatavalid),
        .push_data (rd_readdata),
        .pop       (st_out_fire),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Storage behind an empty FIFO is undefined, so the data output is
    // forced to zero whenever nothing valid is presented.
    assign st_out_valid = !fifo_empty;
    assign st_out_data  = fifo_empty ? 32'd0 : fifo_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if ((rd_words_streamed == in_words_q) && (wr_words_done == out_words_q)) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        rd_read     = 1'b0;
        st_in_ready = 1'b0;
        case (state)
            RUN: begin
                busy        = 1'b1;
                rd_read     = (rd_issued < in_words_q) && (credit_used < CREDIT_LIMIT);
                st_in_ready = (wr_words_accepted < out_words_q) && (!wr_write || !wr_waitrequest);
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_address        <= '0;
            in_words_q        <= '0;
            rd_issued         <= '0;
            rd_words_streamed <= '0;
            rd_outstanding    <= '0;
        end else if (start_accept) begin
            rd_address        <= src_addr;
            in_words_q        <= in_words;
            rd_issued         <= '0;
            rd_words_streamed <= '0;
            rd_outstanding    <= '0;
        end else begin
            if (rd_accept) begin
                rd_address <= rd_address + ADDR_STEP;
                rd_issued  <= rd_issued + 32'd1;
            end
            case ({rd_accept, rd_readdatavalid})
                2'b10:   rd_outstanding <= rd_outstanding + (RD_FIFO_AW + 1)'(1);
                2'b01:   rd_outstanding <= rd_outstanding - (RD_FIFO_AW + 1)'(1);
                default: rd_outstanding <= rd_outstanding;
            endcase
            if (st_out_fire) begin
                rd_words_streamed <= rd_words_streamed + 32'd1;
            end
        end
    end

    // The write holding register refills in the same cycle the slave takes
    // the previous word, which sustains one word per cycle with no bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_address        <= '0;
            wr_write          <= 1'b0;
            wr_writedata      <= '0;
            out_words_q       <= '0;
            wr_words_accepted <= '0;
            wr_words_done     <= '0;
        end else if (start_accept) begin
            wr_address        <= dst_addr;
            wr_write          <= 1'b0;
            out_words_q       <= out_words;
            wr_words_accepted <= '0;
            wr_words_done     <= '0;
        end else begin
            if (wr_accept) begin
                wr_address    <= wr_address + ADDR_STEP;
                wr_words_done <= wr_words_done + 32'd1;
            end
            if (st_in_fire) begin
                wr_writedata      <= st_in_data;
                wr_write          <= 1'b1;
                wr_words_accepted <= wr_words_accepted + 32'd1;
            end else if (wr_accept) begin
                wr_write <= 1'b0;
            end
        end
    end

`ifdef NPU_DMA_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles   <= '0;
            perf_rd_stall <= '0;
            perf_wr_stall <= '0;
        end else if (start_accept) begin
            perf_cycles   <= '0;
            perf_rd_stall <= '0;
            perf_wr_stall <= '0;
        end else begin
            if (state == RUN) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (rd_read && rd_waitrequest) begin
                perf_rd_stall <= perf_rd_stall + 32'd1;
            end
            if (wr_write && wr_waitrequest) begin
                perf_wr_stall <= perf_wr_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/npu_stream_dma.md
Name: npu_stream_dma

Overview:
- Memory-side DMA engine at the far end of the sequencer's 32-bit DMA streaming interface.
- MM2S channel: Avalon-MM read master fetches a packed input buffer from memory and drives it as a valid/ready stream into the sequencer's DMA input.
- S2MM channel: accepts the sequencer's 32-bit result stream and writes it to memory through an Avalon-MM write master.
- Both channels run concurrently under one start/done control; done fires only when all expected words have moved in both directions.

Parameters:
ADDR_WIDTH, 32, byte-address width of both MM masters
RD_FIFO_DEPTH, 8, read-data buffer entries; also the outstanding-read credit limit (power of 2)
RD_FIFO_AW, 3, log2(RD_FIFO_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous assert, active-low
start  in  1  one-cycle launch pulse
src_addr  in  ADDR_WIDTH  MM2S start byte address (word-aligned)
dst_addr  in  ADDR_WIDTH  S2MM start byte address (word-aligned)
in_words  in  32  words to read (2 per core row for N=8)
out_words  in  32  words to write (8 per core row for N=8)
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
rd_address  out  ADDR_WIDTH  read byte address
rd_read  out  1  read request
rd_waitrequest  in  1  slave stall
rd_readdata  in  32  returned data
rd_readdatavalid  in  1  returned-data strobe
st_out_data  out  32  stream to sequencer dma_data_in
st_out_valid  out  1
st_out_ready  in  1
st_in_data  in  32  stream from sequencer dma_data_out
st_in_valid  in  1
st_in_ready  out  1
wr_address  out  ADDR_WIDTH  write byte address
wr_write  out  1  write request
wr_writedata  out  32
wr_waitrequest  in  1

Behaviour:
- Reset values: all outputs 0; rd/wr addresses 0; all counters 0; read FIFO empty; state IDLE.
- Top FSM states: IDLE, RUN, FINISH.
  - IDLE: start latches addresses and word counts, sets busy=1, moves to RUN. start is ignored outside IDLE.
  - RUN: exits to FINISH when rd_words_streamed==in_words AND wr_words_done==out_words.
  - FINISH: done=1 for exactly one cycle, busy=0, return to IDLE.
  - Zero lengths on both counts: RUN→FINISH on the next cycle, so done arrives 2 cycles after start.
- MM2S issue:
  - Hold rd_read=1 while issued<in_words AND (outstanding + fifo_count) < RD_FIFO_DEPTH.
  - A request counts as accepted when rd_read && !rd_waitrequest. On acceptance: rd_address += 4, issued++.
  - rd_address and rd_read hold stable while waitrequest is high.
  - outstanding is incremented on accept and decremented on readdatavalid. Both in the same cycle leaves it unchanged.
- MM2S data path:
  - rd_readdatavalid writes rd_readdata into the FIFO. The credit check guarantees no overflow.
  - The FIFO is first-word-fall-through: st_out_data = FIFO head, st_out_valid = !empty.
  - A pop occurs on st_out_valid && st_out_ready and increments rd_words_streamed.
  - Simultaneous push and pop leaves the count unchanged.
  - Data words leave in memory order with no gaps or duplicates.
  - The output is held stable while valid && !ready.
- S2MM:
  - One-entry holding register; st_in_ready = !wr_write || !wr_waitrequest, gated by RUN and wr_words_accepted<out_words.
  - On an input handshake: wr_writedata <= st_in_data, wr_write=1.
  - On wr_write && !wr_waitrequest: wr_address += 4, wr_words_done++.
  - wr_write drops unless a new input word is accepted in the same cycle, giving back-to-back throughput of 1 word/cycle.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Counts are unsigned 32-bit.
- Asynchronous reset mid-transfer aborts everything immediately.
  - Responses still in flight at reset are the system's responsibility. The block assumes the fabric is reset together with it.

Optional Feature:
NPU_DMA_PERF_EN:
- Defined: adds outputs perf_cycles[31:0], perf_rd_stall[31:0] and perf_wr_stall[31:0].
  - perf_cycles counts cycles in RUN.
  - perf_rd_stall counts cycles with rd_read && rd_waitrequest.
  - perf_wr_stall counts cycles with wr_write && wr_waitrequest.
  - All three clear on start and hold their values after done.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package npu_dma_pkg holds: FSM state encoding (IDLE/RUN/FINISH), WORD_BYTES=4, ROW_IN_WORDS=2, ROW_OUT_WORDS=8.
- One sub-module, npu_dma_rd_fifo: synchronous FWFT FIFO with count output, sized by RD_FIFO_DEPTH.

Test Plan:
- in_words=4, out_words=16, no stalls, ready always 1, src=0x1000, dst=0x2000:
  - st_out carries mem[0x1000..0x100C] in order.
  - Writes land at 0x2000..0x203C.
  - done pulses once; busy falls in the same cycle.
- rd_waitrequest high for 5 cycles on the 2nd read: rd_address=0x1004 held stable; no duplicated or skipped word.
- st_out_ready=0 with read latency 3, in_words=20: outstanding + fifo_count never exceeds 8; all 20 words delivered after ready rises.
- wr_waitrequest toggling every cycle: st_in_ready deasserts accordingly; 8 words written exactly once at consecutive addresses.
- in_words=0, out_words=0: done 2 cycles after start; no rd_read or wr_write ever asserted. A start during busy is ignored.
- rst_n asserted mid-transfer: all outputs 0 immediately. A new start then completes normally.
